// File: rtl/tanh_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision tanh among N_REQ requesters.
// Define TANH_ARB_STATS_EN to add the busy_cycles / ops_done statistics ports.

module HyperbolicTangent (
    input  logic [31:0] num,
    output logic [31:0] result
);
    // Piecewise-linear |x| in [2^-6, 4) with 1/8 steps; abs error below 2e-3.
    function automatic logic [23:0] node(input logic [5:0] k);
        case (k)
            6'd0:  node = 24'd0;        6'd1:  node = 24'd2086296;
            6'd2:  node = 24'd4109059;  6'd3:  node = 24'd6012233;
            6'd4:  node = 24'd7753040;  6'd5:  node = 24'd9304644;
            6'd6:  node = 24'd10656032; 6'd7:  node = 24'd11809566;
            6'd8:  node = 24'd12777430; 6'd9:  node = 24'd13577818;
            6'd10: node = 24'd14231843; 6'd11: node = 24'd14761048;
            6'd12: node = 24'd15185868; 6'd13: node = 24'd15524730;
            6'd14: node = 24'd15793668; 6'd15: node = 24'd16006236;
            6'd16: node = 24'd16173699; 6'd17: node = 24'd16305322;
            6'd18: node = 24'd16408555; 6'd19: node = 24'd16489404;
            6'd20: node = 24'd16552641; 6'd21: node = 24'd16602058;
            6'd22: node = 24'd16640646; 6'd23: node = 24'd16670758;
            6'd24: node = 24'd16694249; 6'd25: node = 24'd16712566;
            6'd26: node = 24'd16726845; 6'd27: node = 24'd16737974;
            6'd28: node = 24'd16746646; 6'd29: node = 24'd16753403;
            6'd30: node = 24'd16758668; 6'd31: node = 24'd16762769;
            6'd32: node = 24'd16765964;
            default: node = 24'd0;
        endcase
    endfunction

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;
    logic [25:0] fx;
    logic [23:0] y0, y1, y;
    logic [44:0] prod;
    logic [4:0]  msb;
    logic [22:0] mant;

    assign sign = num[31];
    assign expo = num[30:23];
    assign frac = num[22:0];

    always_comb begin
        // Q2.24 magnitude; only meaningful for exponents 121..128.
        fx   = {1'b1, frac, 2'b00} >> 3'(8'd128 - expo);
        y0   = node({1'b0, fx[25:21]});
        y1   = node({1'b0, fx[25:21]} + 6'd1);
        prod = 45'(y1 - y0) * 45'(fx[20:0]);
        y    = y0 + 24'(prod >> 21);
        msb  = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            if (y[i]) msb = 5'(i);
        end
        mant = 23'(y << (5'd23 - msb));

        if (expo == 8'hFF && frac != '0)
            result = num | 32'h0040_0000;
        else if (expo >= 8'd129)
            result = {sign, 8'd127, 23'd0};
        else if (expo < 8'd121)
            result = num;
        else
            result = {sign, 8'(8'd103 + 8'(msb)), mant};
    end
endmodule

module tanh_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_data,
    output logic [ID_W-1:0]     resp_id
`ifdef TANH_ARB_STATS_EN
    ,
    output logic [31:0]         busy_cycles,
    output logic [31:0]         ops_done
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr, grant, id_reg;
    logic [ID_W:0]    cand;
    logic             found;
    logic [31:0]      operand, tanh_result;
    logic [CNT_W-1:0] count;

    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                grant = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) req_ready[grant] = 1'b1;
    end

    HyperbolicTangent u_tanh (
        .num    (operand),
        .result (tanh_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_reg     <= '0;
            operand    <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    operand <= req_data[32*grant +: 32];
                    id_reg  <= grant;
                    rr_ptr  <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + ID_W'(1);
                    count   <= CNT_W'(LATENCY-1);
                    state   <= BUSY;
                end
                BUSY: if (count == '0) begin
                    resp_data  <= tanh_result;
                    resp_id    <= id_reg;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end else begin
                    count <= count - CNT_W'(1);
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TANH_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles <= '0;
            ops_done    <= '0;
        end else begin
            if (state == BUSY || state == DONE) busy_cycles <= busy_cycles + 32'd1;
            if (resp_valid && resp_ready) ops_done <= ops_done + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tanh_arbiter.sv
// Directed self-checking bench for tanh_arbiter (N_REQ=4, LATENCY=2).
module tb_tanh_arbiter;
    localparam int unsigned TOL = 32768;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_data;
    logic         resp_valid, resp_ready;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;
`ifdef TANH_ARB_STATS_EN
    logic [31:0]  busy_cycles, ops_done;
`endif

    int unsigned tests, failures;

    tanh_arbiter #(.N_REQ(4), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef TANH_ARB_STATS_EN
        ,
        .busy_cycles(busy_cycles),
        .ops_done   (ops_done)
`endif
    );

    always #5 clk = ~clk;

    // tol is a distance in float bit patterns (same sign required); 0 means exact.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input int unsigned tol);
        logic ok;
        int   d;
        tests++;
        d = int'({1'b0, got[30:0]}) - int'({1'b0, exp[30:0]});
        if (d < 0) d = -d;
        if (tol == 0) ok = (got === exp);
        else          ok = !$isunknown(got) && got[31] == exp[31] && d <= int'(tol);
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic wait_resp(output int unsigned edges_waited);
        edges_waited = 0;
        while (!resp_valid && edges_waited < 20) begin
            @(posedge clk); #1;
            edges_waited++;
        end
    endtask

    task automatic run_single(input int unsigned id, input logic [31:0] op,
                              input logic [31:0] exp, input int unsigned tol, input string tag);
        int unsigned w;
        logic [3:0] onehot;
        onehot = '0;
        onehot[id] = 1'b1;
        req_valid = onehot;
        req_data[32*id +: 32] = op;
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_grant"}, 32'(req_ready), 32'(onehot), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_busy_rdy"}, 32'(req_ready), 32'd0, 0);
        wait_resp(w);
        req_valid = '0;
        check({tag, "_latency"}, 32'(w + 1), 32'd3, 0);
        check({tag, "_data"}, resp_data, exp, tol);
        check({tag, "_id"}, 32'(resp_id), 32'(id), 0);
        @(posedge clk); #1;
        check({tag, "_hs"}, 32'(resp_valid), 32'd0, 0);
    endtask

    initial begin
        int unsigned n, w;
        logic [3:0]  rdy_seen;
        logic [31:0] rr_exp [4];
        tests = 0; failures = 0;
        rst = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(resp_valid), 32'd0, 0);
        check("rst_data", resp_data, 32'd0, 0);
        check("rst_id", 32'(resp_id), 32'd0, 0);
        check("rst_ready", 32'(req_ready), 32'd0, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_single(1, 32'h4000_0000, 32'h3F76_CA83, TOL, "tanh2");
        run_single(2, 32'hC000_0000, 32'hBF76_CA83, TOL, "neg2");
        run_single(3, 32'h41C8_0000, 32'h3F80_0000, TOL, "sat25");
        run_single(0, 32'h3F00_0000, 32'h3EEC_9AA0, TOL, "half");
        run_single(1, 32'h3A80_0000, 32'h3A80_0000, TOL, "tiny");
        run_single(2, 32'h8000_0000, 32'h8000_0000, 0, "negzero");

        // rr_ptr is 3 here; all four request, requester 3 wins, then reset hits mid-BUSY.
        req_data  = {32'h4150_0000, 32'h4080_0000, 32'h4000_0000, 32'hC000_0000};
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        @(negedge clk);
        check("rst_pre_grant", 32'(req_ready), 32'h8, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy_valid", 32'(resp_valid), 32'd0, 0);
        @(posedge clk); #1 rst = 1'b0;
        check("rst_rr_ptr", 32'(req_ready), 32'h1, 0);
        check("rst_no_stale", 32'(resp_valid), 32'd0, 0);

        rr_exp = '{32'hBF76_CA83, 32'h3F76_CA83, 32'h3F7F_D40C, 32'h3F80_0000};
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            rdy_seen = req_ready;
            if (resp_valid) begin
                check($sformatf("rr%0d_id", n), 32'(resp_id), 32'(n), 0);
                check($sformatf("rr%0d_data", n), resp_data, rr_exp[n], TOL);
                n++;
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~rdy_seen;
        end
        check("rr_count", 32'(n), 32'd4, 0);

        // Back-pressure: requester 2 served while requester 0 queues behind it.
        req_data[95:64] = 32'h4000_0000;
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'h4, 0);
        @(posedge clk); #1;
        req_data[31:0] = 32'h3F00_0000;
        req_valid = 4'b0001;
        wait_resp(w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1, 0);
            check("bp_data", resp_data, 32'h3F76_CA83, TOL);
            check("bp_id", 32'(resp_id), 32'd2, 0);
            check("bp_rdy", 32'(req_ready), 32'd0, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(resp_valid), 32'd0, 0);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h1, 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(w);
        check("bp_next_id", 32'(resp_id), 32'd0, 0);
        check("bp_next_data", resp_data, 32'h3EEC_9AA0, TOL);
        @(posedge clk); #1;

`ifdef TANH_ARB_STATS_EN
        rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run_single(0, 32'h4000_0000, 32'h3F76_CA83, TOL, "st0");
        run_single(1, 32'hC000_0000, 32'hBF76_CA83, TOL, "st1");
        run_single(2, 32'h41C8_0000, 32'h3F80_0000, TOL, "st2");
        check("stats_ops", ops_done, 32'd3, 0);
        check("stats_busy", busy_cycles, 32'd9, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
